// File: rtl/jamma_out_serializer.sv
// Serializes a parallel lamp/coin-counter word onto an external SIPO chain:
// MSB-first shift with a DIV-prescaled sclk, followed by a latch strobe.
module jamma_out_serializer #(
  parameter int WIDTH = 16,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             sclk,
  output logic             sdata,
  output logic             latch,
  output logic             done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [BW-1:0] BC_INIT  = BW'(WIDTH - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SHIFT_LO = 2'd1;
  localparam logic [1:0] SHIFT_HI = 2'd2;
  localparam logic [1:0] LATCH    = 2'd3;

  logic [1:0]       state, nxt_state;
  logic [WIDTH-1:0] sh, nxt_sh;
  logic [BW-1:0]    bc, nxt_bc;
  logic [PW-1:0]    pre, nxt_pre;
  logic             pre_end;

  assign ready   = (state == IDLE);
  assign pre_end = (pre == PRE_LAST);

  always_comb begin
    nxt_state = state;
    nxt_sh    = sh;
    nxt_bc    = bc;
    nxt_pre   = pre;
    case (state)
      IDLE: begin
        if (valid) begin
          nxt_sh    = data;
          nxt_bc    = BC_INIT;
          nxt_pre   = '0;
          nxt_state = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (pre_end) begin
          nxt_pre   = '0;
          nxt_state = SHIFT_HI;
        end else begin
          nxt_pre = pre + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (pre_end) begin
          nxt_pre = '0;
          nxt_sh  = {sh[WIDTH-2:0], 1'b0};
          if (bc == '0) begin
            nxt_state = LATCH;
          end else begin
            nxt_bc    = bc - 1'b1;
            nxt_state = SHIFT_LO;
          end
        end else begin
          nxt_pre = pre + 1'b1;
        end
      end
      default: begin
        if (pre_end) begin
          nxt_pre   = '0;
          nxt_state = IDLE;
        end else begin
          nxt_pre = pre + 1'b1;
        end
      end
    endcase
  end

  // Pin outputs are registered from the next-state view so they line up
  // with the state they describe without any combinational decode at the pins.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      sh    <= '0;
      bc    <= '0;
      pre   <= '0;
      sclk  <= 1'b0;
      sdata <= 1'b0;
      latch <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nxt_state;
      sh    <= nxt_sh;
      bc    <= nxt_bc;
      pre   <= nxt_pre;
      sclk  <= (nxt_state == SHIFT_HI);
      sdata <= ((nxt_state == SHIFT_LO) || (nxt_state == SHIFT_HI)) ? nxt_sh[WIDTH-1] : 1'b0;
      latch <= (nxt_state == LATCH);
      done  <= (state == LATCH) && (nxt_state == IDLE);
    end
  end

endmodule
